// File: rtl/mips_pkg.sv
// mips_pkg: constants and types shared by the MIPS pipeline stages.
//   NOP_INSTR     - bubble instruction word loaded into IF/ID
//   PC_STEP       - sequential PC increment (one 32-bit word)
//   fetch_state_t - fetch-stage state: normal fetch, or draining a
//                   redirected in-flight request
package mips_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 5-stage MIPS pipeline.
// Owns the PC, fetches words over a req/ready instruction-memory port and
// loads the IF/ID register (cmd, PCPlusFourD) feeding decode.
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   StallD             - hazard stall: hold PC and IF/ID
//   PCSrcD, PCBranchD  - taken branch from decode and its target
//   imem_req/addr      - fetch request and word-aligned byte address
//   imem_ready/rdata   - fetch completion and instruction word
//   cmd, PCPlusFourD   - IF/ID register outputs
//   PCF                - current fetch PC
//   FetchStall         - this cycle loads a bubble for lack of a word
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallD,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] cmd,
    output logic [31:0] PCPlusFourD,
    output logic [31:0] PCF,
    output logic        FetchStall
);

    fetch_state_t state, state_n;
    logic         buf_valid, buf_valid_n;
    logic [31:0]  buf_data, buf_data_n;
    logic [31:0]  drain_addr, drain_addr_n;
    logic [31:0]  pcf_n, cmd_n, pc4d_n;

    logic         fetch_done;
    logic         drain_done;
    logic         word_avail;
    logic [31:0]  pc_plus4;

    assign pc_plus4 = PCF + PC_STEP;

    // While a word sits in the buffer no new request is made; a drain keeps
    // requesting the abandoned address so the memory contract holds.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = PCF;
        if (state == FETCH) begin
            imem_req  = !reset && !buf_valid;
            imem_addr = PCF;
        end else begin
            imem_req  = !reset;
            imem_addr = drain_addr;
        end
    end

    assign fetch_done = (state == FETCH) && imem_req && imem_ready;
    assign drain_done = (state == DRAIN) && imem_req && imem_ready;
    assign word_avail = buf_valid || fetch_done;

    // Bubble for lack of a word; redirect bubbles are not counted here.
    assign FetchStall = !reset && !StallD && !PCSrcD && !word_avail;

    always_comb begin
        state_n      = state;
        buf_valid_n  = buf_valid;
        buf_data_n   = buf_data;
        drain_addr_n = drain_addr;
        pcf_n        = PCF;
        cmd_n        = cmd;
        pc4d_n       = PCPlusFourD;

        if (StallD) begin
            // Hold IF/ID and PC; park a word that arrives meanwhile.
            if (fetch_done) begin
                buf_valid_n = 1'b1;
                buf_data_n  = imem_rdata;
            end
            if (drain_done)
                state_n = FETCH;
        end else if (PCSrcD) begin
            cmd_n       = NOP_INSTR;
            pc4d_n      = 32'h0;
            pcf_n       = PCBranchD;
            buf_valid_n = 1'b0;
            if (state == FETCH && imem_req && !imem_ready) begin
                drain_addr_n = PCF;
                state_n      = DRAIN;
            end else if (drain_done) begin
                state_n = FETCH;
            end
        end else if (word_avail) begin
            cmd_n       = buf_valid ? buf_data : imem_rdata;
            pc4d_n      = pc_plus4;
            pcf_n       = pc_plus4;
            buf_valid_n = 1'b0;
        end else begin
            cmd_n  = NOP_INSTR;
            pc4d_n = 32'h0;
            if (drain_done)
                state_n = FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            buf_valid   <= 1'b0;
            buf_data    <= 32'h0;
            drain_addr  <= 32'h0;
            PCF         <= RESET_PC;
            cmd         <= NOP_INSTR;
            PCPlusFourD <= 32'h0;
        end else begin
            state       <= state_n;
            buf_valid   <= buf_valid_n;
            buf_data    <= buf_data_n;
            drain_addr  <= drain_addr_n;
            PCF         <= pcf_n;
            cmd         <= cmd_n;
            PCPlusFourD <= pc4d_n;
        end
    end

endmodule
